// File: rtl/msk_affine_pipe.sv
// Share-wise masked XOR/XNOR/A/NOT-A gate, registered through LAT elastic stages.
// Latency LAT cycles, 1 txn/cycle; stalls ripple back so in_ready drops only when every stage is full.
module msk_affine_pipe #(
  parameter int d     = 2,
  parameter int count = 1,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [count*d-1:0]   ina,
  input  logic [count*d-1:0]   inb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [count*d-1:0]   out
);

  localparam int W = count * d;

  logic [W-1:0]   w_res;
  logic [LAT:0]   w_rdy;
  logic [LAT-1:0] w_src_vld;
  logic [W-1:0]   w_src_dat [LAT];
  logic [LAT-1:0] r_vld;
  logic [W-1:0]   r_dat [LAT];

  // Each share slice only ever sees its own share index; only share 0 takes the inversion.
  for (genvar s = 0; s < d; s++) begin : g_share
    assign w_res[s*count +: count] = ina[s*count +: count]
                                   ^ (inb[s*count +: count] & {count{~op[1]}})
                                   ^ {count{(s == 0) && op[0]}};
  end

  always_comb begin
    w_rdy[LAT] = out_ready;
    for (int k = LAT - 1; k >= 0; k--) begin
      w_rdy[k] = ~r_vld[k] | w_rdy[k+1];
    end
  end

  always_comb begin
    w_src_vld[0] = in_valid;
    w_src_dat[0] = w_res;
    for (int k = 1; k < LAT; k++) begin
      w_src_vld[k] = r_vld[k-1];
      w_src_dat[k] = r_dat[k-1];
    end
  end

  // Data only moves with a valid token, so bubbles never overwrite held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_dat[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LAT; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= w_src_vld[k];
          if (w_src_vld[k]) begin
            r_dat[k] <= w_src_dat[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_vld[LAT-1];
  assign out       = r_dat[LAT-1];

endmodule

// File: tb/tb_msk_affine_pipe.sv
// Randomised and directed check of msk_affine_pipe against a share-level and unmasked reference.
module tb_msk_affine_pipe;

  localparam int D = 2;
  localparam int C = 4;
  localparam int L = 2;
  localparam int W = D * C;
  localparam int N_RND = 3000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] ina;
  logic [W-1:0] inb;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;

  logic [W-1:0] q_exp [$];
  logic [C-1:0] q_val [$];
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_dat  = '0;

  always #5 clk = ~clk;

  msk_affine_pipe #(.d(D), .count(C), .LAT(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .ina       (ina),
    .inb       (inb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  function automatic logic [C-1:0] unmask(logic [W-1:0] v);
    logic [C-1:0] u;
    u = '0;
    for (int s = 0; s < D; s++) u ^= v[s*C +: C];
    return u;
  endfunction

  function automatic logic [W-1:0] ref_shares(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    for (int s = 0; s < D; s++) begin
      for (int j = 0; j < C; j++) begin
        logic x;
        x = a[s*C+j] ^ (o[1] ? 1'b0 : b[s*C+j]);
        if (s == 0 && o[0]) x = ~x;
        r[s*C+j] = x;
      end
    end
    return r;
  endfunction

  function automatic logic [C-1:0] ref_value(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
    logic [C-1:0] ua;
    logic [C-1:0] ub;
    ua = unmask(a);
    ub = unmask(b);
    case (o)
      2'b00:   return ua ^ ub;
      2'b01:   return ~(ua ^ ub);
      2'b10:   return ua;
      default: return ~ua;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluates the handshakes of the current cycle, then advances to the next falling edge.
  task automatic tick();
    logic [W-1:0] e;
    logic [C-1:0] v;
    #1;
    if (hold_pend) begin
      chk("hold_vld", out_valid, 1);
      chk("hold_dat", out, hold_dat);
    end
    if (out_valid && out_ready) begin
      chk("sb_nonempty", q_exp.size() > 0, 1);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        v = q_val.pop_front();
        chk("sb_shares", out, e);
        chk("sb_value", unmask(out), v);
      end
    end
    if (in_valid && in_ready) begin
      q_exp.push_back(ref_shares(op, ina, inb));
      q_val.push_back(ref_value(op, ina, inb));
      n_acc++;
    end
    hold_pend = out_valid && !out_ready;
    hold_dat  = out;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic one_txn(string tag, logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b,
                         logic [W-1:0] es, logic [C-1:0] ev);
    op = o; ina = a; inb = b; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_c1_vld"}, out_valid, 0);
    tick();
    chk({tag, "_c2_vld"}, out_valid, 1);
    chk({tag, "_c2_out"}, out, es);
    chk({tag, "_c2_val"}, unmask(out), ev);
    tick();
  endtask

  initial begin
    logic [5:0] seen;
    int acc0;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; ina = '0; inb = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    one_txn("xnor", 2'b01, 8'hA3, 8'h50, 8'hFC, 4'h3);
    one_txn("xor",  2'b00, 8'hA3, 8'h50, 8'hF3, 4'hC);
    one_txn("nota", 2'b11, 8'h61, 8'h5A, 8'h6E, 4'h8);
    one_txn("copy", 2'b10, 8'h61, 8'h5A, 8'h61, 4'h7);

    out_ready = 1'b1;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      op  = 2'(i);
      ina = W'($urandom);
      inb = W'($urandom);
      tick();
      seen[i] = out_valid;
    end
    chk("b2b_pattern", seen, 6'b011110);

    acc0 = n_acc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op  = 2'($urandom);
      ina = W'($urandom);
      inb = W'($urandom);
      tick();
    end
    chk("stall_accepted", n_acc - acc0, 2);
    #1;
    chk("stall_in_ready", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q_exp.size() > 0; i++) tick();
    chk("stall_drained", q_exp.size(), 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op  = 2'($urandom);
      ina = W'($urandom);
      inb = W'($urandom);
      tick();
    end
    chk("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q_exp.delete();
    q_val.delete();
    hold_pend = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_stale", out_valid, 0);
    end

    acc0 = n_acc;
    for (int c = 0; c < 40000 && (n_acc - acc0) < N_RND; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      op  = 2'($urandom);
      ina = W'($urandom);
      inb = W'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q_exp.size() > 0; i++) tick();
    chk("rnd_accepted", n_acc - acc0, N_RND);
    chk("rnd_drained", q_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
